// File: rtl/serial_bit_tx.sv
// serial_bit_tx: accepts a word over valid/ready and replays it one bit per clock on d_out/en_out
module serial_bit_tx #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             d_out,
  output logic             en_out,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic ready_n, d_n, en_n, done_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      sr <= '0;
      load_ready <= 1'b0;
      d_out <= 1'b0;
      en_out <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sr <= sr_n;
      load_ready <= ready_n;
      d_out <= d_n;
      en_out <= en_n;
      done <= done_n;
    end
  end
  // the DONE cycle already advertises ready, so a waiting word is taken there to keep a one-cycle gap
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sr_n = sr;
    ready_n = load_ready;
    d_n = 1'b0;
    en_n = 1'b0;
    done_n = 1'b0;
    case (state)
      S_SHIFT: begin
        if (cnt == CW'(WIDTH-1)) begin
          state_n = S_DONE;
          done_n = 1'b1;
          ready_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
          sr_n = MSB_FIRST ? sr << 1 : sr >> 1;
          d_n = MSB_FIRST ? sr[WIDTH-1] : sr[0];
          en_n = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
        if (load_valid && load_ready) begin
          state_n = S_SHIFT;
          cnt_n = '0;
          sr_n = MSB_FIRST ? load_data << 1 : load_data >> 1;
          d_n = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
          en_n = 1'b1;
          ready_n = 1'b0;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: directed tests for serial_bit_tx in MSB-first and LSB-first builds
module tb_serial_bit_tx;
  logic clk = 1'b0, rst = 1'b0;
  logic a_valid = 1'b0, a_ready, a_d, a_en, a_done;
  logic b_valid = 1'b0, b_ready, b_d, b_en, b_done;
  logic [7:0] a_data = '0, b_data = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .load_valid(a_valid), .load_data(a_data),
    .load_ready(a_ready), .d_out(a_d), .en_out(a_en), .done(a_done));
  serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .load_valid(b_valid), .load_data(b_data),
    .load_ready(b_ready), .d_out(b_d), .en_out(b_en), .done(b_done));
  task automatic accept(input bit sel, input logic [7:0] w);
    int n = 0;
    @(negedge clk);
    if (sel) begin b_valid = 1'b1; b_data = w; end else begin a_valid = 1'b1; a_data = w; end
    while (!(sel ? b_ready : a_ready) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!(sel ? b_ready : a_ready)) begin
      errors++;
      $display("FAIL accept_timeout sel=%0d ready=0 required 1", sel);
    end
    @(posedge clk);
  endtask
  // samples the 8 bit cycles and the following DONE cycle; the first bit cycle also sets the next inputs
  task automatic cap(input bit sel, input logic hold, input logic [7:0] nd,
                     output logic [7:0] w, output int en_cnt, output int bad, output logic fin_ok);
    w = '0; en_cnt = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sel) begin
        w = {b_d, w[7:1]}; en_cnt += int'(b_en); bad += int'(b_ready | b_done);
      end else begin
        w = {w[6:0], a_d}; en_cnt += int'(a_en); bad += int'(a_ready | a_done);
      end
      if (i == 0) begin
        if (sel) begin b_valid = hold; b_data = nd; end else begin a_valid = hold; a_data = nd; end
      end
    end
    @(negedge clk);
    fin_ok = sel ? (b_done && !b_en && !b_d && b_ready) : (a_done && !a_en && !a_d && a_ready);
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if ({a_ready, a_d, a_en, a_done, b_ready, b_en} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 000000", {a_ready, a_d, a_en, a_done, b_ready, b_en});
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b required 0", a_ready); end
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      errors++; $display("FAIL ready_after_release got %b required 11", {a_ready, b_ready});
    end
  endtask
  task automatic test_msb_frame;
    logic [7:0] w; int en_cnt, bad; logic fin;
    accept(1'b0, 8'hA5);
    cap(1'b0, 1'b0, 8'h00, w, en_cnt, bad, fin);
    checks++;
    if (w !== 8'hA5 || en_cnt != 8 || bad != 0 || !fin) begin
      errors++; $display("FAIL msb_A5 got %h en=%0d bad=%0d done=%b required a5 en=8 bad=0 done=1", w, en_cnt, bad, fin);
    end
    @(negedge clk);
    checks++;
    if ({a_done, a_en, a_d, a_ready} !== 4'b0001) begin
      errors++; $display("FAIL after_done got %b required 0001", {a_done, a_en, a_d, a_ready});
    end
  endtask
  task automatic test_lsb_first;
    logic [7:0] w; int en_cnt, bad; logic fin;
    accept(1'b1, 8'h01);
    cap(1'b1, 1'b0, 8'h00, w, en_cnt, bad, fin);
    checks++;
    if (w !== 8'h01 || en_cnt != 8 || bad != 0 || !fin) begin
      errors++; $display("FAIL lsb_01 got %h en=%0d bad=%0d done=%b required 01 en=8 bad=0 done=1", w, en_cnt, bad, fin);
    end
    accept(1'b1, 8'h80);
    cap(1'b1, 1'b0, 8'h00, w, en_cnt, bad, fin);
    checks++;
    if (w !== 8'h80 || en_cnt != 8 || bad != 0 || !fin) begin
      errors++; $display("FAIL lsb_80 got %h en=%0d bad=%0d done=%b required 80 en=8 bad=0 done=1", w, en_cnt, bad, fin);
    end
  endtask
  task automatic test_ignore_busy;
    logic [7:0] w; int en_cnt, bad; logic fin;
    accept(1'b0, 8'h3C);
    cap(1'b0, 1'b1, 8'hFF, w, en_cnt, bad, fin);
    checks++;
    if (w !== 8'h3C || en_cnt != 8 || bad != 0 || !fin) begin
      errors++; $display("FAIL busy_3C got %h en=%0d bad=%0d done=%b required 3c en=8 bad=0 done=1", w, en_cnt, bad, fin);
    end
    cap(1'b0, 1'b0, 8'h00, w, en_cnt, bad, fin);
    checks++;
    if (w !== 8'hFF || en_cnt != 8 || !fin) begin
      errors++; $display("FAIL busy_FF_later got %h en=%0d done=%b required ff en=8 done=1", w, en_cnt, fin);
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] w; int en_cnt, bad; logic fin;
    accept(1'b0, 8'hC3);
    for (int f = 0; f < 3; f++) begin
      cap(1'b0, f < 2, 8'hC3, w, en_cnt, bad, fin);
      checks++;
      if (w !== 8'hC3 || en_cnt != 8 || bad != 0 || !fin) begin
        errors++; $display("FAIL b2b_frame%0d got %h en=%0d bad=%0d done=%b required c3 en=8 bad=0 done=1", f, w, en_cnt, bad, fin);
      end
    end
    @(negedge clk);
    checks++;
    if ({a_en, a_done} !== 2'b00) begin
      errors++; $display("FAIL b2b_stop got en=%b done=%b required 0 0", a_en, a_done);
    end
  endtask
  task automatic test_abort;
    logic [7:0] w; int en_cnt, bad; logic fin; logic [2:0] bits; logic saw_done = 1'b0;
    accept(1'b0, 8'hF0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bits[2-i] = a_d & a_en;
      a_valid = 1'b0;
    end
    checks++;
    if (bits !== 3'b111) begin errors++; $display("FAIL abort_first_bits got %b required 111", bits); end
    #2 rst = 1'b0; #1;
    checks++;
    if ({a_en, a_d, a_ready, a_done} !== 4'b0000) begin
      errors++; $display("FAIL abort_async got %b required 0000", {a_en, a_d, a_ready, a_done});
    end
    for (int i = 0; i < 3; i++) begin @(negedge clk); saw_done |= a_done | a_en; end
    rst = 1'b1;
    @(negedge clk); saw_done |= a_done | a_en;
    checks++;
    if (saw_done || a_ready !== 1'b1) begin
      errors++; $display("FAIL abort_recover got stray=%b ready=%b required 0 1", saw_done, a_ready);
    end
    accept(1'b0, 8'h0F);
    cap(1'b0, 1'b0, 8'h00, w, en_cnt, bad, fin);
    checks++;
    if (w !== 8'h0F || en_cnt != 8 || bad != 0 || !fin) begin
      errors++; $display("FAIL abort_0F got %h en=%0d bad=%0d done=%b required 0f en=8 bad=0 done=1", w, en_cnt, bad, fin);
    end
  endtask
  task automatic test_data_change;
    logic [7:0] w; int en_cnt, bad; logic fin;
    accept(1'b0, 8'hAA);
    cap(1'b0, 1'b0, 8'h00, w, en_cnt, bad, fin);
    checks++;
    if (w !== 8'hAA || en_cnt != 8 || !fin) begin
      errors++; $display("FAIL data_change got %h en=%0d done=%b required aa en=8 done=1", w, en_cnt, fin);
    end
  endtask
  initial begin
    test_reset;
    test_msb_frame;
    test_lsb_first;
    test_ignore_busy;
    test_back_to_back;
    test_abort;
    test_data_change;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
